fft_spi_frame_rx: RTL

// - Receive end of the FFT result SPI link. Deserialises a framed, MSB-first stream of
//   NUM_WORDS x WORD_W words from sck/sdi (sdi changes on sck rising edge) into an internal RAM.
// - sck, sdi and cs_n are oversampled in the clk domain.
// - Posts a complete frame to a downstream consumer via frame_valid/frame_ack and a random-access read port.
// - Used on the bench/loopback FPGA and as the capture stage for spectrum post-processing.

---
 rtl/fft_spi_frame_rx.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fft_spi_frame_rx.sv
// SPI frame receiver: oversamples sck/sdi/cs_n in the clk domain, deserialises MSB-first
// words into a 1W1R frame buffer and hands complete frames to a consumer via frame_valid/frame_ack.
module fft_spi_frame_rx #(
    parameter int WORD_W      = 32,
    parameter int NUM_WORDS   = 512,
    parameter int ADDR_W      = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              sdi,
    input  logic              cs_n,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              frame_valid,
    input  logic              frame_ack,
    output logic              frame_err,
    output logic              overrun,
    output logic [ADDR_W:0]   words_rcvd
);

    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] sck_sync_reg;
    logic [SYNC_STAGES-1:0] sdi_sync_reg;
    logic [SYNC_STAGES-1:0] cs_sync_reg;
    logic                   sck_prev_reg;
    logic                   cs_prev_reg;

    logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [ADDR_W-1:0] word_cnt_reg, word_cnt_next;
    logic [ADDR_W:0]   words_rcvd_reg, words_rcvd_next;
    logic [WORD_W-1:0] shift_reg, shift_next;
    logic              frame_valid_reg;
    logic              frame_err_reg, frame_err_next;
    logic              overrun_reg, overrun_next;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram [NUM_WORDS];
    logic [WORD_W-1:0] rd_data_reg;

    logic sck_s, sdi_s, cs_s;
    logic sck_fall, cs_fall, cs_rise;
    logic [WORD_W-1:0] shifted;

    // Synchronisers idle at the bus rest state so reset release never looks like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync_reg <= '0;
            sdi_sync_reg <= '0;
            cs_sync_reg  <= '1;
            sck_prev_reg <= 1'b0;
            cs_prev_reg  <= 1'b1;
        end else begin
            sck_sync_reg <= {sck_sync_reg[SYNC_STAGES-2:0], sck};
            sdi_sync_reg <= {sdi_sync_reg[SYNC_STAGES-2:0], sdi};
            cs_sync_reg  <= {cs_sync_reg[SYNC_STAGES-2:0], cs_n};
            sck_prev_reg <= sck_s;
            cs_prev_reg  <= cs_s;
        end
    end

    assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync_reg[SYNC_STAGES-1];
    assign cs_s     = cs_sync_reg[SYNC_STAGES-1];
    assign sck_fall = sck_prev_reg & ~sck_s;
    assign cs_fall  = cs_prev_reg & ~cs_s;
    assign cs_rise  = ~cs_prev_reg & cs_s;
    assign shifted  = {shift_reg[WORD_W-2:0], sdi_s};

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        word_cnt_next   = word_cnt_reg;
        words_rcvd_next = words_rcvd_reg;
        shift_next      = shift_reg;
        frame_err_next  = 1'b0;
        overrun_next    = 1'b0;
        ram_we          = 1'b0;
        ram_waddr       = word_cnt_reg;
        ram_wdata       = shifted;

        case (state_reg)
            IDLE: begin
                if (cs_fall) begin
                    state_next      = RECV;
                    bit_cnt_next    = '0;
                    word_cnt_next   = '0;
                    words_rcvd_next = '0;
                end
            end
            RECV: begin
                if (sck_fall) begin
                    shift_next = shifted;
                    if (bit_cnt_reg == BIT_W'(WORD_W - 1)) begin
                        ram_we          = 1'b1;
                        bit_cnt_next    = '0;
                        word_cnt_next   = word_cnt_reg + 1'b1;
                        words_rcvd_next = words_rcvd_reg + 1'b1;
                        if (word_cnt_reg == ADDR_W'(NUM_WORDS - 1)) begin
                            state_next = DONE;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
                // A coincident final sck_fall wins over cs_rise, so a just-completed frame is kept.
                if (cs_rise && state_next != DONE) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                end
            end
            DONE: begin
                if (cs_fall) begin
                    overrun_next = 1'b1;
                end
                if (frame_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            bit_cnt_reg     <= '0;
            word_cnt_reg    <= '0;
            words_rcvd_reg  <= '0;
            shift_reg       <= '0;
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bit_cnt_reg     <= bit_cnt_next;
            word_cnt_reg    <= word_cnt_next;
            words_rcvd_reg  <= words_rcvd_next;
            shift_reg       <= shift_next;
            frame_valid_reg <= (state_next == DONE);
            frame_err_reg   <= frame_err_next;
            overrun_reg     <= overrun_next;
        end
    end

    // Frame buffer: read-before-write on an address collision.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
        rd_data_reg <= ram[rd_addr];
    end

    assign rd_data     = rd_data_reg;
    assign frame_valid = frame_valid_reg;
    assign frame_err   = frame_err_reg;
    assign overrun     = overrun_reg;
    assign words_rcvd  = words_rcvd_reg;

endmodule
